// File: rtl/seeprom_pkg.sv
// Shared definitions for the serial EEPROM Hold/Rdy generator:
// channel FSM encodings and width helper functions.
package seeprom_pkg;

   typedef enum logic {
      ST_WAIT  = 1'b0,
      ST_READY = 1'b1
   } chan_state_t;

   // Ceiling log2; clog2(1) returns 0.
   function automatic int clog2(input int value);
      int res;
      int v;
      res = 0;
      v = value - 1;
      while (v > 0) begin
         res = res + 1;
         v = v >> 1;
      end
      return res;
   endfunction

   // Ceiling log2 but never narrower than one bit, for counters and selects.
   function automatic int clog2_min1(input int value);
      return (clog2(value) < 1) ? 1 : clog2(value);
   endfunction

endpackage

// File: rtl/seeprom_rdy_chan.sv
// One Hold/Rdy channel: Hold synchroniser, stable-low filter FSM,
// not-ready timeout counter and sticky timeout flag.
module seeprom_rdy_chan
   import seeprom_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 3,
   parameter int TIMEOUT     = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic hold,
   input  logic clr,
   output logic rdy,
   output logic to
);

   localparam int            FW    = clog2_min1(FILTER_LEN);
   localparam logic [FW-1:0] FLAST = FW'(FILTER_LEN - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hold_s;
   chan_state_t            state_q;
   chan_state_t            state_d;
   logic [FW-1:0]          fcnt_q;
   logic [FW-1:0]          fcnt_d;
   logic                   in_wait;

   // Plain shift chain; reset loads 1 so the pin is treated as holding until proven low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], hold};
      end
   end

   assign hold_s = sync_q[SYNC_STAGES-1];

   // State and filter counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_WAIT;
         fcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
      end
   end

   // Drop ready on any high sample; rise only after FILTER_LEN consecutive low samples.
   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      case (state_q)
         ST_WAIT: begin
            if (hold_s) begin
               fcnt_d = '0;
            end else if (fcnt_q == FLAST) begin
               state_d = ST_READY;
               fcnt_d  = '0;
            end else begin
               fcnt_d = fcnt_q + FW'(1);
            end
         end
         ST_READY: begin
            fcnt_d = '0;
            if (hold_s) begin
               state_d = ST_WAIT;
            end
         end
         default: begin
            state_d = ST_WAIT;
            fcnt_d  = '0;
         end
      endcase
   end

   // Ready is a straight decode of the registered state.
   always_comb begin
      rdy     = (state_q == ST_READY);
      in_wait = (state_q == ST_WAIT);
   end

   if (TIMEOUT > 0) begin : g_timeout
      localparam int            TW   = clog2(TIMEOUT + 1);
      localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
      localparam logic [TW-1:0] TPRE = TW'(TIMEOUT - 1);

      logic [TW-1:0] tcnt_q;
      logic          to_q;
      logic          go_ready;
      logic          reach;
      logic          timed_out;

      assign go_ready  = in_wait && (state_d == ST_READY);
      assign reach     = in_wait && !go_ready && (tcnt_q == TPRE);
      assign timed_out = in_wait && (tcnt_q == TMAX);

      // Count not-ready cycles, saturating, and restart the moment ready returns.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            tcnt_q <= '0;
         end else if (go_ready) begin
            tcnt_q <= '0;
         end else if (in_wait && (tcnt_q != TMAX)) begin
            tcnt_q <= tcnt_q + TW'(1);
         end
      end

      // Sticky flag: reaching the limit beats a clear; a clear while still saturated re-arms next cycle.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            to_q <= 1'b0;
         end else if (reach) begin
            to_q <= 1'b1;
         end else if (clr) begin
            to_q <= 1'b0;
         end else if (timed_out) begin
            to_q <= 1'b1;
         end
      end

      assign to = to_q;
   end else begin : g_no_timeout
      logic unused_clr;
      assign unused_clr = clr;
      assign to         = 1'b0;
   end

endmodule

// File: rtl/seeprom_rdy_mc.sv
// Multi-channel ready generator for serial EEPROM Hold lines: one
// independent channel per Hold pin plus a channel-select readback.
module seeprom_rdy_mc
   import seeprom_pkg::*;
#(
   parameter int N_CH        = 2,
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 3,
   parameter int TIMEOUT     = 8
) (
   input  logic                        SCK,
   input  logic                        Rst,
   input  logic [N_CH-1:0]             Hold,
   input  logic [N_CH-1:0]             Clr,
   input  logic [clog2_min1(N_CH)-1:0] Sel,
   output logic [N_CH-1:0]             Rdy,
   output logic [N_CH-1:0]             TO,
   output logic                        Rdy_Sel,
   output logic                        TO_Sel
);

   localparam int SEL_W = clog2_min1(N_CH);

   for (genvar i = 0; i < N_CH; i++) begin : g_chan
      seeprom_rdy_chan #(
         .SYNC_STAGES (SYNC_STAGES),
         .FILTER_LEN  (FILTER_LEN),
         .TIMEOUT     (TIMEOUT)
      ) u_chan (
         .clk  (SCK),
         .rst  (Rst),
         .hold (Hold[i]),
         .clr  (Clr[i]),
         .rdy  (Rdy[i]),
         .to   (TO[i])
      );
   end

   // Select readback; a select value with no matching channel reads as 0.
   always_comb begin
      Rdy_Sel = 1'b0;
      TO_Sel  = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         if (Sel == SEL_W'(i)) begin
            Rdy_Sel = Rdy[i];
            TO_Sel  = TO[i];
         end
      end
   end

endmodule

// File: tb/tb_seeprom_rdy_mc.sv
// Bench for seeprom_rdy_mc (2 channels, 2 sync stages, filter 3, timeout 8).
// Inputs change on the falling edge; expectations are queued with the cycle
// they apply to and checked 1 ns after that rising edge.
module tb_seeprom_rdy_mc;

   logic       SCK;
   logic       Rst;
   logic [1:0] Hold;
   logic [1:0] Clr;
   logic [0:0] Sel;
   logic [1:0] Rdy;
   logic [1:0] TO;
   logic       Rdy_Sel;
   logic       TO_Sel;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   localparam logic [5:0] C_RDY = 6'b110000;
   localparam logic [5:0] C_TO  = 6'b001100;
   localparam logic [5:0] C_SEL = 6'b000011;
   localparam logic [5:0] C_ALL = 6'b111111;

   typedef struct {
      string      name;
      int         at;
      logic [5:0] val;
      logic [5:0] care;
   } exp_t;

   typedef struct {
      logic [1:0] hold;
      logic [1:0] clr;
      logic       sel;
      int         n;
      logic [1:0] rdy;
      logic [1:0] to;
      logic       rs;
      logic       ts;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[7];

   seeprom_rdy_mc #(
      .N_CH        (2),
      .SYNC_STAGES (2),
      .FILTER_LEN  (3),
      .TIMEOUT     (8)
   ) dut (
      .SCK     (SCK),
      .Rst     (Rst),
      .Hold    (Hold),
      .Clr     (Clr),
      .Sel     (Sel),
      .Rdy     (Rdy),
      .TO      (TO),
      .Rdy_Sel (Rdy_Sel),
      .TO_Sel  (TO_Sel)
   );

   // 20 ns clock, first rising edge at 10 ns.
   initial begin
      SCK = 1'b0;
      forever #10 SCK = ~SCK;
   end

   task automatic check_output(input string name, input logic [5:0] act,
                               input logic [5:0] exp, input logic [5:0] care);
      checks = checks + 1;
      if ((act & care) !== (exp & care)) begin
         failures = failures + 1;
         $display("[TB] FAIL %s at cycle %0d: got {Rdy,TO,RdySel,TOSel}=%b expected %b (care %b)",
                  name, cyc, act, exp, care);
      end
   endtask

   task automatic apply_stimulus(input logic [1:0] hold, input logic [1:0] clr, input logic sel);
      Hold = hold;
      Clr  = clr;
      Sel  = sel;
   endtask

   task automatic expect_at(input string name, input int delta,
                            input logic [5:0] val, input logic [5:0] care);
      exp_t e;
      e.name = name;
      e.at   = cyc + delta;
      e.val  = val;
      e.care = care;
      sb.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge SCK);
   endtask

   // Count rising edges and retire the expectations due on this one.
   always @(posedge SCK) begin
      cyc = cyc + 1;
      #1;
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].at == cyc) begin
            check_output(sb[i].name, {Rdy, TO, Rdy_Sel, TO_Sel}, sb[i].val, sb[i].care);
            sb.delete(i);
         end
      end
   end

   initial begin
      vecs[0] = '{hold:2'b00, clr:2'b00, sel:1'b0, n:2, rdy:2'b11, to:2'b00, rs:1'b1, ts:1'b0};
      vecs[1] = '{hold:2'b01, clr:2'b00, sel:1'b0, n:3, rdy:2'b10, to:2'b00, rs:1'b0, ts:1'b0};
      vecs[2] = '{hold:2'b01, clr:2'b00, sel:1'b1, n:2, rdy:2'b10, to:2'b00, rs:1'b1, ts:1'b0};
      vecs[3] = '{hold:2'b00, clr:2'b00, sel:1'b0, n:5, rdy:2'b11, to:2'b00, rs:1'b1, ts:1'b0};
      vecs[4] = '{hold:2'b10, clr:2'b00, sel:1'b1, n:2, rdy:2'b11, to:2'b00, rs:1'b1, ts:1'b0};
      vecs[5] = '{hold:2'b10, clr:2'b00, sel:1'b1, n:1, rdy:2'b01, to:2'b00, rs:1'b0, ts:1'b0};
      vecs[6] = '{hold:2'b00, clr:2'b00, sel:1'b1, n:5, rdy:2'b11, to:2'b00, rs:1'b1, ts:1'b0};

      Rst = 1'b1;
      apply_stimulus(2'b00, 2'b00, 1'b0);
      #50;
      check_output("reset_state", {Rdy, TO, Rdy_Sel, TO_Sel}, 6'b000000, C_ALL);
      #51;
      Rst = 1'b0;
      // Release lands before edge cyc+1; ready rises four edges after that one.
      expect_at("reset_rdy_low", 4, {2'b00, 2'b00, 2'b00}, C_RDY | C_TO);
      expect_at("reset_rdy_rise", 5, {2'b11, 2'b00, 2'b00}, C_RDY | C_TO);
      step(5);

      for (int v = 0; v < 7; v++) begin
         apply_stimulus(vecs[v].hold, vecs[v].clr, vecs[v].sel);
         expect_at($sformatf("vec%0d", v), vecs[v].n,
                   {vecs[v].rdy, vecs[v].to, vecs[v].rs, vecs[v].ts}, C_ALL);
         step(vecs[v].n);
      end

      // Hold[0] rises: Rdy[0] falls exactly two edges after the next one, Rdy[1] untouched.
      apply_stimulus(2'b01, 2'b00, 1'b0);
      expect_at("assert_before", 2, {2'b11, 4'b0000}, C_RDY);
      expect_at("assert_drop", 3, {2'b10, 4'b0000}, C_RDY);
      step(3);

      // Two low samples then high again: filter never completes.
      apply_stimulus(2'b00, 2'b00, 1'b0);
      expect_at("glitch_short_a", 5, {2'b10, 4'b0000}, C_RDY);
      expect_at("glitch_short_b", 8, {2'b10, 4'b0000}, C_RDY);
      step(2);
      apply_stimulus(2'b01, 2'b00, 1'b0);
      step(6);

      // Ch0 has now been not-ready long enough to time out; a sustained low releases it.
      apply_stimulus(2'b00, 2'b00, 1'b0);
      expect_at("glitch_long_pre", 4, {2'b10, 2'b01, 2'b00}, C_RDY | C_TO);
      expect_at("glitch_long_rise", 5, {2'b11, 2'b01, 1'b1, 1'b1}, C_ALL);
      step(5);
      apply_stimulus(2'b00, 2'b01, 1'b0);
      expect_at("clr0", 1, {2'b11, 2'b00, 2'b00}, C_RDY | C_TO);
      step(1);
      apply_stimulus(2'b00, 2'b00, 1'b0);

      // Ch1 timeout, clear while still saturated, release and final clear.
      apply_stimulus(2'b10, 2'b00, 1'b1);
      expect_at("to_rdy_drop", 3, {2'b01, 2'b00, 2'b00}, C_RDY | C_TO);
      expect_at("to_before", 10, {2'b01, 2'b00, 1'b0, 1'b0}, C_ALL);
      expect_at("to_set", 11, {2'b01, 2'b10, 1'b0, 1'b1}, C_ALL);
      step(13);
      apply_stimulus(2'b10, 2'b10, 1'b1);
      expect_at("to_clr_while_out", 1, {2'b01, 2'b00, 2'b00}, C_RDY | C_TO);
      expect_at("to_reset_again", 2, {2'b01, 2'b10, 2'b00}, C_RDY | C_TO);
      step(1);
      apply_stimulus(2'b10, 2'b00, 1'b1);
      step(1);
      apply_stimulus(2'b00, 2'b00, 1'b1);
      expect_at("to_sticky_rdy", 5, {2'b11, 2'b10, 1'b1, 1'b1}, C_ALL);
      step(5);
      apply_stimulus(2'b00, 2'b10, 1'b1);
      expect_at("clr1", 1, {2'b11, 2'b00, 1'b1, 1'b0}, C_ALL);
      step(1);
      apply_stimulus(2'b00, 2'b00, 1'b0);
      expect_at("sel0", 1, {2'b11, 2'b00, 1'b1, 1'b0}, C_ALL);
      step(1);

      // Clear arriving on the very edge the counter reaches the limit loses to the set.
      apply_stimulus(2'b10, 2'b00, 1'b1);
      expect_at("coll_drop", 3, {2'b01, 2'b00, 2'b00}, C_RDY | C_TO);
      step(10);
      apply_stimulus(2'b10, 2'b10, 1'b1);
      expect_at("coll_set_wins", 1, {2'b01, 2'b10, 1'b0, 1'b1}, C_ALL);
      step(1);
      apply_stimulus(2'b10, 2'b00, 1'b1);
      expect_at("coll_hold", 1, {2'b01, 2'b10, 1'b0, 1'b1}, C_ALL);
      step(2);

      // Asynchronous reset mid-timeout clears everything without waiting for an edge.
      #3;
      Rst = 1'b1;
      #1;
      check_output("async_reset", {Rdy, TO, Rdy_Sel, TO_Sel}, 6'b000000, C_ALL);
      #6;
      Rst = 1'b0;
      step(3);

      for (int i = 0; i < sb.size(); i++) begin
         checks   = checks + 1;
         failures = failures + 1;
         $display("[TB] FAIL %s: expectation for cycle %0d never retired (now %0d)",
                  sb[i].name, sb[i].at, cyc);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
